// File: rtl/roberto_sched_tx.sv
`default_nettype none
// ============================================================================
//  Module   : roberto_sched_tx
//  Purpose  : Scan scheduler for the three ultrasonic channels. Channels are
//             fired one at a time to avoid acoustic crosstalk. Each enabled
//             channel's 3-digit BCD result is streamed over the single shared
//             serial transmitter as four ASCII characters: three digits and a
//             separator. Supports single-shot and continuous scanning.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//   clock         in   1   system clock, rising edge
//   reset         in   1   synchronous, active-high, returns block to IDLE
//   ligar         in   1   one-cycle start pulse (already edge-detected)
//   continuo      in   1   1 = repeat scans after INTERVALO_CICLOS
//   habilita      in   3   per-sensor enable mask
//   med_start     out  3   one-cycle start pulse to sensor i
//   med_pronto    in   3   one-cycle done pulse from sensor i
//   med_dado0/1/2 in  12   BCD result {hundreds,tens,units} per sensor
//   tx_partida    out  1   one-cycle transmit request for tx_dado
//   tx_dado       out  7   ASCII character to transmit
//   tx_pronto     in   1   one-cycle pulse, current character fully sent
//   pronto        out  1   one-cycle pulse at the end of each scan
//   timeout_flag  out  3   sticky per-sensor timeout of the last scan
//   db_sensor     out  2   index of the sensor being serviced
//   db_estado     out  4   FSM state code
// ============================================================================
module roberto_sched_tx #(
    parameter int TIMEOUT_CICLOS   = 2_500_000,
    parameter int INTERVALO_CICLOS = 25_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ligar,
    input  logic        continuo,
    input  logic [2:0]  habilita,
    output logic [2:0]  med_start,
    input  logic [2:0]  med_pronto,
    input  logic [11:0] med_dado0,
    input  logic [11:0] med_dado1,
    input  logic [11:0] med_dado2,
    output logic        tx_partida,
    output logic [6:0]  tx_dado,
    input  logic        tx_pronto,
    output logic        pronto,
    output logic [2:0]  timeout_flag,
    output logic [1:0]  db_sensor,
    output logic [3:0]  db_estado
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_MAX_CICLOS = (TIMEOUT_CICLOS > INTERVALO_CICLOS) ?
                                  TIMEOUT_CICLOS : INTERVALO_CICLOS;
    localparam int c_CW         = $clog2(c_MAX_CICLOS) + 1;

    // Last value of the wait counter before the measurement is abandoned.
    localparam logic [c_CW-1:0] c_TO_LAST  = c_CW'(TIMEOUT_CICLOS - 1);

    // The pause is measured from the FIM cycle to the next med_start.
    // SELECIONA and DISPARA consume two of those cycles, so the INTERVALO
    // state itself lasts INTERVALO_CICLOS-2 cycles (counter 0..N-3).
    localparam logic [c_CW-1:0] c_INT_LAST = (INTERVALO_CICLOS >= 3) ?
                                             c_CW'(INTERVALO_CICLOS - 3) :
                                             '0;

    localparam logic [6:0] c_ASCII_0   = 7'h30;
    localparam logic [6:0] c_ASCII_ERR = 7'h3F;  // '?'
    localparam logic [6:0] c_ASCII_SEP = 7'h2C;  // ','
    localparam logic [6:0] c_ASCII_END = 7'h23;  // '#'

    localparam logic [3:0] c_ST_IDLE       = 4'd0;
    localparam logic [3:0] c_ST_SELECIONA  = 4'd1;
    localparam logic [3:0] c_ST_DISPARA    = 4'd2;
    localparam logic [3:0] c_ST_ESPERA_MED = 4'd3;
    localparam logic [3:0] c_ST_CARREGA    = 4'd4;
    localparam logic [3:0] c_ST_TRANSMITE  = 4'd5;
    localparam logic [3:0] c_ST_ESPERA_TX  = 4'd6;
    localparam logic [3:0] c_ST_FIM        = 4'd7;
    localparam logic [3:0] c_ST_INTERVALO  = 4'd8;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [3:0]      r_estado;
    logic [1:0]      r_sensor;     // 2'd3 means "past the last sensor"
    logic [1:0]      r_char_idx;
    logic [c_CW-1:0] r_cnt;
    logic [11:0]     r_dado;
    logic            r_valido;
    logic [2:0]      r_timeout;
    logic [6:0]      r_tx_dado;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [2:0]  w_sensor_oh;
    logic        w_pronto_sel;
    logic [11:0] w_dado_sel;
    logic        w_ultimo;
    logic        w_sel_found;
    logic [1:0]  w_sel_idx;
    logic [3:0]  w_nibble;
    logic [6:0]  w_char;

    // One-hot of the current sensor; zero when the index is past the end,
    // which also keeps out-of-range indices away from the 3-bit vectors.
    always_comb begin
        w_sensor_oh  = 3'b000;
        w_pronto_sel = 1'b0;
        w_dado_sel   = 12'h000;
        w_ultimo     = 1'b1;
        case (r_sensor)
            2'd0: begin
                w_sensor_oh  = 3'b001;
                w_pronto_sel = med_pronto[0];
                w_dado_sel   = med_dado0;
                w_ultimo     = ~|habilita[2:1];
            end
            2'd1: begin
                w_sensor_oh  = 3'b010;
                w_pronto_sel = med_pronto[1];
                w_dado_sel   = med_dado1;
                w_ultimo     = ~habilita[2];
            end
            2'd2: begin
                w_sensor_oh  = 3'b100;
                w_pronto_sel = med_pronto[2];
                w_dado_sel   = med_dado2;
                w_ultimo     = 1'b1;
            end
            default: begin
                w_sensor_oh  = 3'b000;
                w_pronto_sel = 1'b0;
                w_dado_sel   = 12'h000;
                w_ultimo     = 1'b1;
            end
        endcase
    end

    // Lowest enabled sensor at or above the current index. Disabled sensors
    // are skipped in a single SELECIONA cycle, so an all-zero mask reaches
    // FIM immediately.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (habilita[i] && (2'(i) >= r_sensor)) begin
                w_sel_found = 1'b1;
                w_sel_idx   = 2'(i);
            end
        end
    end

    // Character for the current index: hundreds, tens, units, separator.
    always_comb begin
        w_nibble = 4'h0;
        w_char   = c_ASCII_ERR;
        case (r_char_idx)
            2'd0:    w_nibble = r_dado[11:8];
            2'd1:    w_nibble = r_dado[7:4];
            2'd2:    w_nibble = r_dado[3:0];
            default: w_nibble = 4'h0;
        endcase
        if (r_char_idx == 2'd3) begin
            w_char = w_ultimo ? c_ASCII_END : c_ASCII_SEP;
        end else if (!r_valido || (w_nibble > 4'd9)) begin
            w_char = c_ASCII_ERR;
        end else begin
            w_char = c_ASCII_0 + {3'b000, w_nibble};
        end
    end

    // ------------------------------------------------------------------
    // Main sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= c_ST_IDLE;
            r_sensor   <= 2'd0;
            r_char_idx <= 2'd0;
            r_cnt      <= '0;
            r_dado     <= 12'h000;
            r_valido   <= 1'b0;
            r_timeout  <= 3'b000;
            r_tx_dado  <= 7'h00;
        end else begin
            case (r_estado)
                c_ST_IDLE: begin
                    if (ligar) begin
                        r_estado  <= c_ST_SELECIONA;
                        r_sensor  <= 2'd0;
                        r_timeout <= 3'b000;
                    end
                end

                c_ST_SELECIONA: begin
                    if (w_sel_found) begin
                        r_sensor <= w_sel_idx;
                        r_estado <= c_ST_DISPARA;
                    end else begin
                        r_estado <= c_ST_FIM;
                    end
                end

                c_ST_DISPARA: begin
                    r_cnt    <= '0;
                    r_estado <= c_ST_ESPERA_MED;
                end

                c_ST_ESPERA_MED: begin
                    // A reply on the final counter cycle still counts as valid.
                    if (w_pronto_sel) begin
                        r_dado     <= w_dado_sel;
                        r_valido   <= 1'b1;
                        r_char_idx <= 2'd0;
                        r_estado   <= c_ST_CARREGA;
                    end else if (r_cnt == c_TO_LAST) begin
                        r_timeout  <= r_timeout | w_sensor_oh;
                        r_valido   <= 1'b0;
                        r_char_idx <= 2'd0;
                        r_estado   <= c_ST_CARREGA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_ST_CARREGA: begin
                    r_tx_dado <= w_char;
                    r_estado  <= c_ST_TRANSMITE;
                end

                c_ST_TRANSMITE: begin
                    r_estado <= c_ST_ESPERA_TX;
                end

                c_ST_ESPERA_TX: begin
                    if (tx_pronto) begin
                        if (r_char_idx != 2'd3) begin
                            r_char_idx <= r_char_idx + 2'd1;
                            r_estado   <= c_ST_CARREGA;
                        end else begin
                            // From sensor 2 this wraps to 3 = no more sensors.
                            r_sensor <= r_sensor + 2'd1;
                            r_estado <= c_ST_SELECIONA;
                        end
                    end
                end

                c_ST_FIM: begin
                    r_cnt    <= '0;
                    r_estado <= continuo ? c_ST_INTERVALO : c_ST_IDLE;
                end

                c_ST_INTERVALO: begin
                    if (r_cnt == c_INT_LAST) begin
                        r_sensor  <= 2'd0;
                        r_timeout <= 3'b000;
                        r_estado  <= c_ST_SELECIONA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_estado <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    assign med_start    = (r_estado == c_ST_DISPARA) ? w_sensor_oh : 3'b000;
    assign tx_partida   = (r_estado == c_ST_TRANSMITE);
    assign pronto       = (r_estado == c_ST_FIM);
    assign tx_dado      = r_tx_dado;
    assign timeout_flag = r_timeout;
    assign db_sensor    = r_sensor;
    assign db_estado    = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_roberto_sched_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_roberto_sched_tx
//  Purpose  : Self-checking bench for roberto_sched_tx. Sensor and
//             transmitter responders react to the DUT; a scan-level model
//             predicts the character stream, start order and timeout flags.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_roberto_sched_tx;

    localparam int T = 20;
    localparam int I = 30;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ligar = 1'b0;
    logic        continuo = 1'b0;
    logic [2:0]  habilita = 3'b000;
    logic [2:0]  med_start;
    logic [2:0]  med_pronto = 3'b000;
    logic [11:0] dat [3];
    logic [11:0] med_dado0, med_dado1, med_dado2;
    logic        tx_partida;
    logic [6:0]  tx_dado;
    logic        tx_pronto = 1'b0;
    logic        pronto;
    logic [2:0]  timeout_flag;
    logic [1:0]  db_sensor;
    logic [3:0]  db_estado;

    assign med_dado0 = dat[0];
    assign med_dado1 = dat[1];
    assign med_dado2 = dat[2];

    roberto_sched_tx #(
        .TIMEOUT_CICLOS   (T),
        .INTERVALO_CICLOS (I)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ligar        (ligar),
        .continuo     (continuo),
        .habilita     (habilita),
        .med_start    (med_start),
        .med_pronto   (med_pronto),
        .med_dado0    (med_dado0),
        .med_dado1    (med_dado1),
        .med_dado2    (med_dado2),
        .tx_partida   (tx_partida),
        .tx_dado      (tx_dado),
        .tx_pronto    (tx_pronto),
        .pronto       (pronto),
        .timeout_flag (timeout_flag),
        .db_sensor    (db_sensor),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Responder / monitor state
    int         cyc = 0;
    int         dly [3];          // reply delay per sensor, <=0 = never
    int         pr_at [3];
    int         txp_at = -1;
    bit         tx_hold = 1'b0;
    bit         tx_force = 1'b0;
    logic [6:0] tx_cur = 7'h00;
    int         onehot_bad = 0;
    int         stab_bad = 0;
    int         st_s [$];
    int         st_c [$];
    logic [6:0] tx_q [$];
    int         pr_c [$];

    // Model outputs
    string      exp_tx;
    string      exp_st;
    logic [2:0] exp_fl;

    // Cycle N is the interval following the Nth falling edge; outputs are
    // sampled there and responder inputs for cycle N are driven there.
    initial begin
        for (int i = 0; i < 3; i++) pr_at[i] = -1;
        forever begin
            @(negedge clock);
            cyc++;
            med_pronto = 3'b000;
            tx_pronto  = tx_force;
            if (reset) begin
                for (int i = 0; i < 3; i++) pr_at[i] = -1;
                txp_at = -1;
            end
            if (med_start != 3'b000) begin
                if (!$onehot(med_start)) onehot_bad++;
                for (int i = 0; i < 3; i++) begin
                    if (med_start[i]) begin
                        st_s.push_back(i);
                        st_c.push_back(cyc);
                        if (dly[i] > 0) pr_at[i] = cyc + dly[i];
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (pr_at[i] == cyc) begin
                    med_pronto[i] = 1'b1;
                    pr_at[i] = -1;
                end
            end
            if (tx_partida) begin
                tx_q.push_back(tx_dado);
                tx_cur = tx_dado;
                if (!tx_hold) txp_at = cyc + 1 + int'($urandom_range(0, 3));
            end
            if (txp_at == cyc) begin
                tx_pronto = 1'b1;
                if (tx_dado !== tx_cur) stab_bad++;
                txp_at = -1;
            end
            if (pronto) pr_c.push_back(cyc);
        end
    end

    // Scan-level reference: what one scan must emit for the current
    // habilita / dat / dly settings.
    function automatic void build_expect();
        int last;
        last   = -1;
        exp_tx = "";
        exp_st = "";
        exp_fl = 3'b000;
        for (int i = 0; i < 3; i++) if (habilita[i]) last = i;
        for (int i = 0; i < 3; i++) begin
            if (habilita[i]) begin
                bit ok;
                ok = (dly[i] >= 1) && (dly[i] <= T);
                exp_st = {exp_st, $sformatf("%0d", i)};
                if (!ok) exp_fl[i] = 1'b1;
                for (int d = 2; d >= 0; d--) begin
                    int nib;
                    nib = int'((dat[i] >> (4 * d)) & 12'h00F);
                    if (ok && nib <= 9) exp_tx = {exp_tx, $sformatf("%0d", nib)};
                    else                exp_tx = {exp_tx, "?"};
                end
                if (i == 2 || i == last) exp_tx = {exp_tx, "#"};
                else                     exp_tx = {exp_tx, ","};
            end
        end
    endfunction

    function automatic string txs();
        string s;
        s = "";
        foreach (tx_q[k]) s = {s, $sformatf("%c", tx_q[k])};
        return s;
    endfunction

    function automatic string sts();
        string s;
        s = "";
        foreach (st_s[k]) s = {s, $sformatf("%0d", st_s[k])};
        return s;
    endfunction

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic clear_logs();
        st_s.delete();
        st_c.delete();
        tx_q.delete();
        pr_c.delete();
        onehot_bad = 0;
        stab_bad   = 0;
    endtask

    task automatic pulse_ligar(output int l);
        ligar = 1'b1;
        l     = cyc;
        step();
        ligar = 1'b0;
    endtask

    task automatic wait_pronto(input int n, output bit ok);
        int b;
        b = 0;
        while (pr_c.size() < n && b < 1500) begin
            step();
            b++;
        end
        ok = (pr_c.size() >= n);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        total++;
        if (db_estado !== 4'd0) begin
            bad++; $display("FAIL reset_estado got=%0d want=0", db_estado);
        end
        total++;
        if ({med_start, tx_partida, pronto, timeout_flag, db_sensor, tx_dado} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0",
                            {med_start, tx_partida, pronto, timeout_flag, db_sensor, tx_dado});
        end
        reset = 1'b0;
        clear_logs();
        repeat (6) step();
        total++;
        if (db_estado !== 4'd0 || st_s.size() != 0 || tx_q.size() != 0) begin
            bad++; $display("FAIL reset_idle estado=%0d starts=%0d tx=%0d want 0/0/0",
                            db_estado, st_s.size(), tx_q.size());
        end
    endtask

    task automatic test_scan_basic();
        int l; bit ok;
        habilita = 3'b111; continuo = 1'b0;
        dat[0] = 12'h123; dat[1] = 12'h045; dat[2] = 12'h300;
        dly[0] = 5; dly[1] = 5; dly[2] = 5;
        build_expect();
        clear_logs();
        pulse_ligar(l);
        wait_pronto(1, ok);
        step(); step();
        total++;
        if (!ok) begin bad++; $display("FAIL basic_pronto_wait got=none want=pulse"); end
        total++;
        if (txs() != "123,045,300#") begin
            bad++; $display("FAIL basic_stream got=%s want=123,045,300#", txs());
        end
        total++;
        if (sts() != "012") begin bad++; $display("FAIL basic_starts got=%s want=012", sts()); end
        total++;
        if (st_c.size() == 0 || st_c[0] != l + 2) begin
            bad++; $display("FAIL basic_start_latency got=%0d want=%0d",
                            (st_c.size() == 0) ? -1 : st_c[0] - l, 2);
        end
        total++;
        if (pr_c.size() != 1) begin bad++; $display("FAIL basic_pronto_count got=%0d want=1", pr_c.size()); end
        total++;
        if (timeout_flag !== 3'b000) begin bad++; $display("FAIL basic_flags got=%b want=000", timeout_flag); end
        total++;
        if (onehot_bad != 0 || stab_bad != 0) begin
            bad++; $display("FAIL basic_protocol onehot_bad=%0d stab_bad=%0d want 0/0", onehot_bad, stab_bad);
        end
        total++;
        if (db_estado !== 4'd0) begin bad++; $display("FAIL basic_back_idle got=%0d want=0", db_estado); end
    endtask

    task automatic test_timeout();
        int l; bit ok;
        habilita = 3'b101;
        dat[0] = 12'h007; dat[2] = 12'h999;
        dly[0] = 3; dly[1] = 3; dly[2] = -1;
        build_expect();
        clear_logs();
        pulse_ligar(l);
        wait_pronto(1, ok);
        step(); step();
        total++;
        if (!ok || txs() != "007,???#") begin
            bad++; $display("FAIL timeout_stream got=%s want=007,???#", txs());
        end
        total++;
        if (timeout_flag !== 3'b100) begin bad++; $display("FAIL timeout_flags got=%b want=100", timeout_flag); end
        total++;
        if (sts() != "02") begin bad++; $display("FAIL timeout_starts got=%s want=02", sts()); end
    endtask

    task automatic test_same_cycle();
        int l; bit ok;
        habilita = 3'b010;
        dat[1] = 12'h456;
        dly[1] = T;              // reply lands on the final counter cycle
        build_expect();
        clear_logs();
        pulse_ligar(l);
        wait_pronto(1, ok);
        step(); step();
        total++;
        if (!ok || txs() != "456#") begin bad++; $display("FAIL same_cycle_stream got=%s want=456#", txs()); end
        total++;
        if (timeout_flag !== 3'b000) begin bad++; $display("FAIL same_cycle_flags got=%b want=000", timeout_flag); end
        dly[1] = T + 1;          // one cycle too late
        clear_logs();
        pulse_ligar(l);
        wait_pronto(1, ok);
        step(); step();
        total++;
        if (!ok || txs() != "???#") begin bad++; $display("FAIL late_reply_stream got=%s want=???#", txs()); end
        total++;
        if (timeout_flag !== 3'b010) begin bad++; $display("FAIL late_reply_flags got=%b want=010", timeout_flag); end
    endtask

    task automatic test_none();
        int l; bit ok;
        habilita = 3'b000;
        clear_logs();
        pulse_ligar(l);
        wait_pronto(1, ok);
        step(); step();
        total++;
        if (!ok || pr_c[0] != l + 2) begin
            bad++; $display("FAIL none_pronto_latency got=%0d want=2", ok ? pr_c[0] - l : -1);
        end
        total++;
        if (st_s.size() != 0 || tx_q.size() != 0) begin
            bad++; $display("FAIL none_traffic starts=%0d tx=%0d want 0/0", st_s.size(), tx_q.size());
        end
        total++;
        if (pr_c.size() != 1) begin bad++; $display("FAIL none_pronto_count got=%0d want=1", pr_c.size()); end
    endtask

    task automatic test_continuous();
        int l, dummy, f, b; bit ok;
        string s1, s2;
        habilita = 3'b001; continuo = 1'b1;
        dat[0] = 12'h089; dly[0] = -1;
        build_expect(); s1 = exp_tx;
        clear_logs();
        pulse_ligar(l);
        b = 0;
        while (st_s.size() < 1 && b < 100) begin step(); b++; end
        step(); step();
        pulse_ligar(dummy);      // mid-scan start request must be ignored
        wait_pronto(1, ok);
        total++;
        if (!ok || timeout_flag !== 3'b001) begin
            bad++; $display("FAIL cont_first_flags got=%b want=001", timeout_flag);
        end
        f = ok ? pr_c[0] : 0;
        step();
        continuo = 1'b0;         // already sampled at FIM: interval continues
        dly[0] = 4;
        build_expect(); s2 = exp_tx;
        b = 0;
        while (st_s.size() < 2 && b < 200) begin step(); b++; end
        total++;
        if (st_c.size() < 2 || st_c[1] != f + I) begin
            bad++; $display("FAIL cont_interval got=%0d want=%0d",
                            (st_c.size() < 2) ? -1 : st_c[1] - f, I);
        end
        wait_pronto(2, ok);
        total++;
        if (!ok || timeout_flag !== 3'b000) begin
            bad++; $display("FAIL cont_flags_cleared got=%b want=000", timeout_flag);
        end
        repeat (60) step();
        total++;
        if (txs() != {s1, s2}) begin bad++; $display("FAIL cont_stream got=%s want=%s%s", txs(), s1, s2); end
        total++;
        if (st_s.size() != 2 || pr_c.size() != 2) begin
            bad++; $display("FAIL cont_scan_count starts=%0d pronto=%0d want 2/2", st_s.size(), pr_c.size());
        end
        total++;
        if (db_estado !== 4'd0) begin bad++; $display("FAIL cont_stop got=%0d want=0", db_estado); end
    endtask

    task automatic test_reset_mid();
        int l, b;
        habilita = 3'b111; continuo = 1'b0;
        dly[0] = 3; dly[1] = 3; dly[2] = 3;
        tx_hold = 1'b1;
        clear_logs();
        pulse_ligar(l);
        b = 0;
        while (tx_q.size() < 1 && b < 100) begin step(); b++; end
        step();
        total++;
        if (db_estado !== 4'd6) begin bad++; $display("FAIL rmid_in_espera_tx got=%0d want=6", db_estado); end
        reset = 1'b1;
        step();
        total++;
        if (db_estado !== 4'd0) begin bad++; $display("FAIL rmid_estado got=%0d want=0", db_estado); end
        total++;
        if ({med_start, tx_partida, pronto, timeout_flag, db_sensor, tx_dado} !== '0) begin
            bad++; $display("FAIL rmid_outputs got=%h want=0",
                            {med_start, tx_partida, pronto, timeout_flag, db_sensor, tx_dado});
        end
        reset = 1'b0;
        clear_logs();
        tx_force = 1'b1;         // late completion from the aborted character
        step();
        tx_force = 1'b0;
        repeat (40) step();
        total++;
        if (st_s.size() != 0 || tx_q.size() != 0 || pr_c.size() != 0 || db_estado !== 4'd0) begin
            bad++; $display("FAIL rmid_quiet starts=%0d tx=%0d pronto=%0d estado=%0d want 0/0/0/0",
                            st_s.size(), tx_q.size(), pr_c.size(), db_estado);
        end
        tx_hold = 1'b0;
    endtask

    task automatic test_random();
        int l; bit ok;
        for (int n = 0; n < 10; n++) begin
            habilita = 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                dat[i] = 12'($urandom);
                if ($urandom_range(0, 5) == 0) dly[i] = -1;
                else dly[i] = int'($urandom_range(1, T + 2));
            end
            build_expect();
            clear_logs();
            pulse_ligar(l);
            wait_pronto(1, ok);
            step(); step();
            total++;
            if (!ok || txs() != exp_tx) begin
                bad++; $display("FAIL rand%0d_stream hab=%b got=%s want=%s", n, habilita, txs(), exp_tx);
            end
            total++;
            if (sts() != exp_st) begin bad++; $display("FAIL rand%0d_starts got=%s want=%s", n, sts(), exp_st); end
            total++;
            if (timeout_flag !== exp_fl) begin
                bad++; $display("FAIL rand%0d_flags got=%b want=%b", n, timeout_flag, exp_fl);
            end
            total++;
            if (pr_c.size() != 1 || onehot_bad != 0 || stab_bad != 0) begin
                bad++; $display("FAIL rand%0d_protocol pronto=%0d onehot_bad=%0d stab_bad=%0d want 1/0/0",
                                n, pr_c.size(), onehot_bad, stab_bad);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            dat[i] = 12'h000;
            dly[i] = 1;
        end
        reset = 1'b1;
        step(); step(); step();
        test_reset();
        test_scan_basic();
        test_timeout();
        test_same_cycle();
        test_none();
        test_continuous();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
